// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, bus ACK/NACK levels and
// error-flag bit positions. Used by both i2c_slave and i2c_master.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IGNORE
  } i2c_state_t;

  // Bus level of the acknowledge bit.
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  // Bit positions in the sticky error vector.
  localparam int ERR_ADDR_NACK = 0;
  localparam int ERR_RD_NACK   = 1;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA input synchroniser with edge and bus-condition detection.
// Produces single-cycle pulses for SCL edges and START/STOP conditions.
// rst is asynchronous and active-low.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_prev;
  logic                   sda_prev;
  logic                   scl_s;

  // Synchroniser chains plus one history flop; reset to the idle-bus level.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbour, giving a true shift chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_prev <= scl_sync[SYNC_STAGES-1];
      sda_prev <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  assign scl_rise  =  scl_s & ~scl_prev;
  assign scl_fall  = ~scl_s &  scl_prev;
  // SDA may only move with SCL high for START/STOP; both samples must be high.
  assign start_det =  scl_s &  scl_prev & ~sda_s &  sda_prev;
  assign stop_det  =  scl_s &  scl_prev &  sda_s & ~sda_prev;

endmodule

// File: rtl/i2c_slave.sv
// I2C target with a bank of byte registers behind a register pointer.
// Write: ADDR+W, pointer byte, data bytes (pointer auto-increments).
// Read:  ADDR+R, data bytes from the current pointer until master NACK.
// rst is asynchronous and active-low.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         NUM_REGS    = 16,
  parameter int         SYNC_STAGES = 2,
  localparam int        PTR_W       = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl,
  inout  tri               sda,
  input  logic [PTR_W-1:0] host_addr,
  output logic [7:0]       host_rdata,
  output logic             wr_strobe,
  output logic [PTR_W-1:0] wr_addr,
  output logic             busy,
  output logic [1:0]       error
);

  logic             sda_s;
  logic             scl_rise;
  logic             scl_fall;
  logic             start_det;
  logic             stop_det;

  i2c_state_t       state;
  logic [3:0]       bit_cnt;
  logic [7:0]       shift;
  logic [PTR_W-1:0] ptr;
  logic             sda_oe;
  logic             ack_on;
  logic             rw;
  logic [7:0]       wr_data;
  logic [7:0]       regs [NUM_REGS];

  logic [7:0]       rx_byte;
  logic [PTR_W-1:0] ptr_inc;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda       (sda),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  // Open-drain: only ever pull low or release.
  assign sda = sda_oe ? 1'b0 : 1'bz;

  assign rx_byte    = {shift[6:0], sda_s};
  assign ptr_inc    = ptr + PTR_W'(1);
  assign host_rdata = regs[host_addr];

  // Register bank, written one cycle after the strobe so a host read in the
  // strobe cycle still returns the old value.
  // NOTE: the bank is reset because the register map defines power-on values
  // of zero; a plain storage RAM would not be reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
    end else if (wr_strobe) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Protocol FSM: START/STOP override everything, else bit-level handling.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      ptr       <= '0;
      sda_oe    <= 1'b0;
      ack_on    <= 1'b0;
      rw        <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      error     <= '0;
    end else begin
      wr_strobe <= 1'b0;
      if (stop_det) begin
        state   <= ST_IDLE;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
        bit_cnt <= '0;
        ack_on  <= 1'b0;
      end else if (start_det) begin
        state   <= ST_ADDR;
        sda_oe  <= 1'b0;
        bit_cnt <= '0;
        ack_on  <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE, ST_IGNORE: sda_oe <= 1'b0;

          ST_ADDR, ST_PTR, ST_WR_DATA: begin
            if (scl_rise) begin
              shift   <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= '0;
                if (state == ST_ADDR) begin
                  if (rx_byte[7:1] == SLAVE_ADDR) begin
                    rw    <= rx_byte[0];
                    busy  <= 1'b1;
                    state <= ST_ADDR_ACK;
                  end else begin
                    error[ERR_ADDR_NACK] <= 1'b1;
                    state                <= ST_IGNORE;
                  end
                end else if (state == ST_PTR) begin
                  ptr   <= rx_byte[PTR_W-1:0];
                  state <= ST_PTR_ACK;
                end else begin
                  wr_strobe <= 1'b1;
                  wr_addr   <= ptr;
                  wr_data   <= rx_byte;
                  state     <= ST_WR_ACK;
                end
              end
            end
          end

          // ACK slot: drive on the first falling edge, release on the next.
          ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: begin
            if (scl_fall) begin
              if (!ack_on) begin
                sda_oe <= ~I2C_ACK;
                ack_on <= 1'b1;
              end else begin
                ack_on <= 1'b0;
                sda_oe <= 1'b0;
                if (state == ST_ADDR_ACK && rw) begin
                  // The ACK-ending edge also launches the first data bit.
                  shift   <= {regs[ptr][6:0], 1'b0};
                  sda_oe  <= ~regs[ptr][7];
                  bit_cnt <= 4'd1;
                  state   <= ST_RD_DATA;
                end else if (state == ST_ADDR_ACK) begin
                  state <= ST_PTR;
                end else if (state == ST_PTR_ACK) begin
                  state <= ST_WR_DATA;
                end else begin
                  ptr   <= ptr_inc;
                  state <= ST_WR_DATA;
                end
              end
            end
          end

          ST_RD_DATA: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
                state   <= ST_RD_ACK;
              end else begin
                sda_oe  <= ~shift[7];
                shift   <= {shift[6:0], 1'b0};
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end

          ST_RD_ACK: begin
            if (scl_rise) begin
              if (sda_s == I2C_NACK) begin
                error[ERR_RD_NACK] <= 1'b1;
                state              <= ST_IGNORE;
              end else begin
                ptr     <= ptr_inc;
                shift   <= regs[ptr_inc];
                bit_cnt <= '0;
                state   <= ST_RD_DATA;
              end
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bit-banged I2C master, a byte-level model
// of the register bank / pointer / error flags, and a monitor that checks
// every wr_strobe against the writes the model expects.
module tb_i2c_slave;

  localparam int Q = 4;   // quarter SCL period in clk cycles (SCL = clk/16)

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl = 1'b1;
  logic       m_oe = 1'b0;
  tri         sda;
  logic [3:0] host_addr = 4'h0;
  logic [7:0] host_rdata;
  logic       wr_strobe;
  logic [3:0] wr_addr;
  logic       busy;
  logic [1:0] error;
  logic       sda_bit;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [7:0] m_regs [16];
  logic [3:0] m_ptr;
  logic [1:0] m_err;
  int         exp_wr [$];
  logic [7:0] rd_log [4];

  pullup (sda);
  assign sda = m_oe ? 1'b0 : 1'bz;
  assign sda_bit = (sda === 1'b0) ? 1'b0 : 1'b1;

  always #5 clk = ~clk;

  i2c_slave #(.SLAVE_ADDR(7'h50), .NUM_REGS(16), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .scl        (scl),
    .sda        (sda),
    .host_addr  (host_addr),
    .host_rdata (host_rdata),
    .wr_strobe  (wr_strobe),
    .wr_addr    (wr_addr),
    .busy       (busy),
    .error      (error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Every bus write must match the next write the model predicted.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && wr_strobe) begin
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_strobe: unexpected strobe at wr_addr %0h, expected none", wr_addr);
        end else begin
          check("wr_addr", {28'd0, wr_addr}, exp_wr.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_q();
    repeat (Q) @(posedge clk);
  endtask

  task automatic i2c_start();
    m_oe = 1'b0; wait_q();
    scl  = 1'b1; wait_q();
    m_oe = 1'b1; wait_q();
    scl  = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    m_oe = 1'b1; wait_q();
    scl  = 1'b1; wait_q();
    m_oe = 1'b0; wait_q(); wait_q();
  endtask

  task automatic send_bit(input logic b);
    m_oe = ~b; wait_q();
    scl  = 1'b1; wait_q(); wait_q();
    scl  = 1'b0; wait_q();
  endtask

  task automatic recv_bit(output logic b);
    m_oe = 1'b0; wait_q();
    scl  = 1'b1; wait_q();
    #1 b = sda_bit;
    wait_q();
    scl  = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(ack);
  endtask

  // Addressed write: pointer then n (0..2) data bytes.
  task automatic bus_write(input logic [7:0] ptr, input int n,
                           input logic [7:0] d0, input logic [7:0] d1,
                           input logic do_stop);
    logic ack;
    logic [7:0] d;
    i2c_start();
    write_byte(8'hA0, ack);
    check("addr_w ack", {31'd0, ack}, 0);
    check("busy in transfer", {31'd0, busy}, 1);
    write_byte(ptr, ack);
    check("ptr ack", {31'd0, ack}, 0);
    m_ptr = ptr[3:0];
    for (int k = 0; k < n; k++) begin
      d = (k == 0) ? d0 : d1;
      exp_wr.push_back(int'(m_ptr));
      write_byte(d, ack);
      check("data ack", {31'd0, ack}, 0);
      m_regs[m_ptr] = d;
      m_ptr = m_ptr + 4'd1;
    end
    if (do_stop) i2c_stop();
  endtask

  // Addressed read of n bytes from the current pointer; NACK on the last.
  task automatic bus_read(input int n);
    logic ack;
    logic [7:0] got;
    i2c_start();
    write_byte(8'hA1, ack);
    check("addr_r ack", {31'd0, ack}, 0);
    for (int k = 0; k < n; k++) begin
      read_byte(got, (k == n - 1) ? 1'b1 : 1'b0);
      rd_log[k] = got;
      check("read byte", {24'd0, got}, {24'd0, m_regs[m_ptr]});
      if (k == n - 1) m_err[1] = 1'b1;
      else            m_ptr = m_ptr + 4'd1;
    end
    // Master has released SDA for the NACK; the slave must not hold it.
    #1 check("sda released after nack", {31'd0, sda_bit}, 1);
    i2c_stop();
  endtask

  task automatic peek(input logic [3:0] a, output logic [7:0] d);
    host_addr = a;
    @(negedge clk);
    d = host_rdata;
  endtask

  task automatic checkpoint();
    logic [7:0] d;
    repeat (4) @(posedge clk);
    check("busy idle", {31'd0, busy}, 0);
    check("error", {30'd0, error}, {30'd0, m_err});
    check("pending writes", exp_wr.size(), 0);
    for (int i = 0; i < 16; i++) begin
      peek(i[3:0], d);
      check("reg", {24'd0, d}, {24'd0, m_regs[i]});
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    m_ptr = 4'h0;
    m_err = 2'b00;
    exp_wr.delete();
  endtask

  initial begin
    logic       ack;
    logic       b;
    logic [7:0] d;
    model_reset();

    // Reset state
    repeat (4) @(posedge clk);
    #1;
    check("reset sda", {31'd0, sda_bit}, 1);
    check("reset wr_strobe", {31'd0, wr_strobe}, 0);
    rst = 1'b1;
    checkpoint();

    // Write 0xA5, 0x5A from pointer 3
    bus_write(8'h03, 2, 8'hA5, 8'h5A, 1'b1);
    checkpoint();
    peek(4'h3, d); check("lit reg3", {24'd0, d}, 32'hA5);
    peek(4'h4, d); check("lit reg4", {24'd0, d}, 32'h5A);

    // Pointer write, repeated START, read two bytes (ACK then NACK)
    bus_write(8'h03, 0, 8'h00, 8'h00, 1'b0);
    bus_read(2);
    checkpoint();
    check("lit rd0", {24'd0, rd_log[0]}, 32'hA5);
    check("lit rd1", {24'd0, rd_log[1]}, 32'h5A);
    check("lit error rd nack", {30'd0, error}, 32'h2);

    // Wrong address 0x51: no ACK, not busy
    i2c_start();
    write_byte(8'hA2, ack);
    check("bad addr nack", {31'd0, ack}, 1);
    #1 check("bad addr busy", {31'd0, busy}, 0);
    m_err[0] = 1'b1;
    i2c_stop();
    checkpoint();
    check("lit error both", {30'd0, error}, 32'h3);

    // Pointer wrap on write
    bus_write(8'h0F, 2, 8'h11, 8'h22, 1'b1);
    checkpoint();
    peek(4'hF, d); check("lit reg15", {24'd0, d}, 32'h11);
    peek(4'h0, d); check("lit reg0", {24'd0, d}, 32'h22);

    // STOP after 4 bits of a data byte: byte discarded
    i2c_start();
    write_byte(8'hA0, ack);
    check("abort addr ack", {31'd0, ack}, 0);
    write_byte(8'h07, ack);
    check("abort ptr ack", {31'd0, ack}, 0);
    m_ptr = 4'h7;
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    i2c_stop();
    checkpoint();

    // Reset while the slave drives a 0 bit of reg7 (0x00)
    i2c_start();
    write_byte(8'hA1, ack);
    check("rst addr ack", {31'd0, ack}, 0);
    recv_bit(b); check("rst rd bit7", {31'd0, b}, 0);
    recv_bit(b); check("rst rd bit6", {31'd0, b}, 0);
    #1 check("slave driving", {31'd0, sda_bit}, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check("sda released by reset", {31'd0, sda_bit}, 1);
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    i2c_stop();
    checkpoint();

    // Read without pointer write continues from the stored pointer, wrapping
    bus_write(8'h0F, 2, 8'h3C, 8'h7E, 1'b1);
    bus_write(8'h0F, 0, 8'h00, 8'h00, 1'b1);
    bus_read(3);
    checkpoint();
    check("lit wrap rd0", {24'd0, rd_log[0]}, 32'h3C);
    check("lit wrap rd1", {24'd0, rd_log[1]}, 32'h7E);
    check("lit wrap rd2", {24'd0, rd_log[2]}, 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
